// File: rtl/idex_pkg.sv
// Shared constants for the ID/EX pipeline register: instruction field positions,
// default bundle widths and the all-zero bubble control word.
package idex_pkg;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int REG_IDX_W = RS_MSB - RS_LSB + 1;

  localparam int XLEN_DEF         = 32;
  localparam int NUM_SRC_DEF      = 2;
  localparam int WB_W_DEF         = 2;
  localparam int M_W_DEF          = 3;
  localparam int EX_W_DEF         = 4;
  localparam int MEM_READ_BIT_DEF = 0;

  // A bubble carries no control at all; sliced down to each bundle width.
  localparam logic [31:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/idex_hazard_unit.sv
// Load-use comparator: flags when the load sitting in EX writes a register that
// the instruction in ID reads. Instantiated only when IDEX_HAZARD_DET_EN is defined.
module idex_hazard_unit
  import idex_pkg::*;
(
  input  logic                 stall,
  input  logic                 exValid,
  input  logic                 exMemRead,
  input  logic [REG_IDX_W-1:0] exRt,
  input  logic                 idValid,
  input  logic [REG_IDX_W-1:0] idRs,
  input  logic [REG_IDX_W-1:0] idRt,
  output logic                 hazard
);

  logic loadInEx;
  logic srcMatch;

  assign loadInEx = exValid && exMemRead && (exRt != '0);
  assign srcMatch = (exRt == idRs) || (exRt == idRt);

  // A held stage must never be turned into a bubble, so stall masks the request.
  assign hazard = !stall && loadInEx && idValid && srcMatch;

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register with valid bit, stall/flush control and optional
// load-use bubble insertion (enabled by defining IDEX_HAZARD_DET_EN).
module idex_stage_reg
  import idex_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int WB_W         = WB_W_DEF,
  parameter int M_W          = M_W_DEF,
  parameter int EX_W         = EX_W_DEF,
  parameter int MEM_READ_BIT = MEM_READ_BIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    id_valid_i,
  input  logic [NUM_SRC*XLEN-1:0] rs_data_i,
  input  logic [XLEN-1:0]         imm_i,
  input  logic [XLEN-1:0]         instr_i,
  input  logic [WB_W-1:0]         wb_i,
  input  logic [M_W-1:0]          m_i,
  input  logic [EX_W-1:0]         ex_i,
  output logic [NUM_SRC*XLEN-1:0] rs_data_o,
  output logic [XLEN-1:0]         imm_o,
  output logic [XLEN-1:0]         instr_o,
  output logic [WB_W-1:0]         wb_o,
  output logic [M_W-1:0]          m_o,
  output logic [EX_W-1:0]         ex_o,
  output logic                    ex_valid_o,
  output logic                    hazard_o
);

  if (MEM_READ_BIT >= M_W) begin : gBadMemReadBit
    $error("MEM_READ_BIT must index a bit of the M bundle");
  end

  logic hazard;

`ifdef IDEX_HAZARD_DET_EN
  idex_hazard_unit uHazard (
    .stall     (stall_i),
    .exValid   (ex_valid_o),
    .exMemRead (m_o[MEM_READ_BIT]),
    .exRt      (instr_o[RT_MSB:RT_LSB]),
    .idValid   (id_valid_i),
    .idRs      (instr_i[RS_MSB:RS_LSB]),
    .idRt      (instr_i[RT_MSB:RT_LSB]),
    .hazard    (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  assign hazard_o = hazard;

  // Stage protocol: ex_valid_o marks a real instruction in EX. Each edge does
  // exactly one of flush (bubble) > stall (hold) > hazard (bubble) > load.
  // An invalid ID slot loads with all control zeroed so it cannot write state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o <= 1'b0;
      rs_data_o  <= '0;
      imm_o      <= '0;
      instr_o    <= '0;
      wb_o       <= BUBBLE_CTRL[WB_W-1:0];
      m_o        <= BUBBLE_CTRL[M_W-1:0];
      ex_o       <= BUBBLE_CTRL[EX_W-1:0];
    end else if (flush_i || (!stall_i && hazard)) begin
      ex_valid_o <= 1'b0;
      rs_data_o  <= '0;
      imm_o      <= '0;
      instr_o    <= '0;
      wb_o       <= BUBBLE_CTRL[WB_W-1:0];
      m_o        <= BUBBLE_CTRL[M_W-1:0];
      ex_o       <= BUBBLE_CTRL[EX_W-1:0];
    end else if (!stall_i) begin
      ex_valid_o <= id_valid_i;
      rs_data_o  <= rs_data_i;
      imm_o      <= imm_i;
      instr_o    <= instr_i;
      wb_o       <= id_valid_i ? wb_i : BUBBLE_CTRL[WB_W-1:0];
      m_o        <= id_valid_i ? m_i  : BUBBLE_CTRL[M_W-1:0];
      ex_o       <= id_valid_i ? ex_i : BUBBLE_CTRL[EX_W-1:0];
    end
  end

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: directed scenarios then random traffic, all checked
// against a stage-content model built from the load/hold/bubble rules.
module tb_idex_stage_reg;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 2;
  localparam int WB_W    = 2;
  localparam int M_W     = 3;
  localparam int EX_W    = 4;

`ifdef IDEX_HAZARD_DET_EN
  localparam bit HZ_EN = 1'b1;
`else
  localparam bit HZ_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    stall_i, flush_i, id_valid_i;
  logic [NUM_SRC*XLEN-1:0] rs_data_i, rs_data_o;
  logic [XLEN-1:0]         imm_i, instr_i, imm_o, instr_o;
  logic [WB_W-1:0]         wb_i, wb_o;
  logic [M_W-1:0]          m_i, m_o;
  logic [EX_W-1:0]         ex_i, ex_o;
  logic                    ex_valid_o, hazard_o;

  int checks = 0;
  int errors = 0;

  // reference model of what the EX stage should hold
  logic                    md_valid;
  logic [NUM_SRC*XLEN-1:0] md_rs;
  logic [XLEN-1:0]         md_imm, md_instr;
  logic [WB_W-1:0]         md_wb;
  logic [M_W-1:0]          md_m;
  logic [EX_W-1:0]         md_ex;

  idex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .rs_data_i(rs_data_i), .imm_i(imm_i),
    .instr_i(instr_i), .wb_i(wb_i), .m_i(m_i), .ex_i(ex_i),
    .rs_data_o(rs_data_o), .imm_o(imm_o), .instr_o(instr_o), .wb_o(wb_o),
    .m_o(m_o), .ex_o(ex_o), .ex_valid_o(ex_valid_o), .hazard_o(hazard_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    md_valid = 1'b0; md_rs = '0; md_imm = '0; md_instr = '0;
    md_wb = '0; md_m = '0; md_ex = '0;
  endtask

  function automatic bit model_hazard();
    int ex_rt, id_rs, id_rt;
    ex_rt = int'((md_instr >> 16) & 32'h1f);
    id_rs = int'((instr_i >> 21) & 32'h1f);
    id_rt = int'((instr_i >> 16) & 32'h1f);
    return HZ_EN && !stall_i && md_valid && md_m[0] && (ex_rt != 0) && id_valid_i &&
           (ex_rt == id_rs || ex_rt == id_rt);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "/valid"}, 64'(ex_valid_o), 64'(md_valid));
    check({tag, "/rs"},    rs_data_o,       md_rs);
    check({tag, "/imm"},   64'(imm_o),      64'(md_imm));
    check({tag, "/instr"}, 64'(instr_o),    64'(md_instr));
    check({tag, "/wb"},    64'(wb_o),       64'(md_wb));
    check({tag, "/m"},     64'(m_o),        64'(md_m));
    check({tag, "/ex"},    64'(ex_o),       64'(md_ex));
  endtask

  task automatic set_in(input logic v, input logic [63:0] rs, input logic [31:0] imm,
                        input logic [31:0] ins, input logic [1:0] wb, input logic [2:0] m,
                        input logic [3:0] ex);
    id_valid_i = v; rs_data_i = rs; imm_i = imm; instr_i = ins;
    wb_i = wb; m_i = m; ex_i = ex;
  endtask

  // Inputs are set just after a rising edge; check hazard, step model, clock, check stage.
  task automatic cycle(input string tag);
    bit hz;
    #2;
    hz = model_hazard();
    check({tag, "/hazard"}, 64'(hazard_o), 64'(hz));
    if (flush_i || hz) model_clear();
    else if (!stall_i) begin
      md_valid = id_valid_i; md_rs = rs_data_i; md_imm = imm_i; md_instr = instr_i;
      md_wb = id_valid_i ? wb_i : '0;
      md_m  = id_valid_i ? m_i  : '0;
      md_ex = id_valid_i ? ex_i : '0;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    check_outputs({tag, "/now"});
    check({tag, "/hazard"}, 64'(hazard_o), 64'd0);
    @(posedge clk);
    #1;
    check_outputs({tag, "/held"});
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] mk_instr(input int op, input int rs, input int rt, input int low);
    return {6'(op), 5'(rs), 5'(rt), 16'(low)};
  endfunction

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    set_in(1'b0, '0, '0, '0, '0, '0, '0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset/hazard", 64'(hazard_o), 64'd0);
    rst_n = 1'b1;

    // normal load
    set_in(1'b1, {32'h2, 32'h1}, 32'hFFFF_FFF0, mk_instr(0, 3, 4, 16'h2020), 2'b11, 3'b110, 4'hA);
    cycle("load");
    check("load/dir_valid", 64'(ex_valid_o), 64'd1);
    check("load/dir_imm", 64'(imm_o), 64'hFFFF_FFF0);

    // async reset mid-stream with nonzero outputs
    async_reset("rst_mid");

    // stall holds for three edges, then new inputs load
    set_in(1'b1, 64'h1111_2222_3333_4444, 32'h5, mk_instr(8, 1, 2, 7), 2'b01, 3'b010, 4'h3);
    cycle("pre_stall");
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, {$urandom, $urandom}, $urandom, mk_instr(9, i, i + 1, i), 2'b10, 3'b100, 4'(i));
      cycle("stall");
      check("stall/dir_instr", 64'(instr_o), 64'(mk_instr(8, 1, 2, 7)));
    end
    stall_i = 1'b0;
    cycle("unstall");

    // flush beats stall
    flush_i = 1'b1; stall_i = 1'b1;
    cycle("flush_stall");
    check("flush_stall/dir_valid", 64'(ex_valid_o), 64'd0);
    flush_i = 1'b0; stall_i = 1'b0;

    // invalid slot loads with control zeroed
    set_in(1'b0, 64'hABCD, 32'h1, mk_instr(0, 5, 6, 0), 2'b11, 3'b111, 4'hF);
    cycle("invalid");

    // load-use: lw rt=5 then add rs=5
    set_in(1'b1, 64'h10, 32'h4, mk_instr(6'h23, 1, 5, 4), 2'b11, 3'b001, 4'h1);
    cycle("lw");
    set_in(1'b1, 64'h20, 32'h0, mk_instr(0, 5, 2, 16'h1820), 2'b10, 3'b000, 4'h2);
    cycle("lu_first");
    check("lu_first/dir_valid", 64'(ex_valid_o), 64'(!HZ_EN));
    cycle("lu_second");
    check("lu_second/dir_instr", 64'(instr_o), 64'(mk_instr(0, 5, 2, 16'h1820)));
    check("lu_second/dir_valid", 64'(ex_valid_o), 64'd1);

    // load with rt=0 never hazards
    set_in(1'b1, 64'h10, 32'h4, mk_instr(6'h23, 1, 0, 4), 2'b11, 3'b001, 4'h1);
    cycle("lw_r0");
    set_in(1'b1, 64'h20, 32'h0, mk_instr(0, 0, 0, 16'h0020), 2'b10, 3'b000, 4'h2);
    #2;
    check("lu_r0/dir_hazard", 64'(hazard_o), 64'd0);
    #0;
    cycle("lu_r0");

    // random traffic
    for (int n = 0; n < 300; n++) begin
      if (n == 150) async_reset("rst_rand");
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      set_in($urandom_range(0, 4) != 0, {$urandom, $urandom}, $urandom,
             mk_instr($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7), $urandom),
             2'($urandom), 3'($urandom), 4'($urandom));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
